// File: rtl/acc_job_sched_pkg.sv
// Shared types and constants for the accumulator job scheduler.
package acc_job_sched_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam int CW = 7;
endpackage

// File: rtl/acc_job_sched_if.sv
// Client, datapath and result signals of the scheduler; slave is the scheduler side.
interface acc_job_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [NREQ*8-1:0] smp_data;
    logic [NREQ-1:0]   smp_vld;
    logic [NREQ-1:0]   smp_rdy;
    logic              dp_clr;
    logic              dp_en;
    logic [7:0]        dp_in;
    logic [W-1:0]      dp_y;
    logic              res_vld;
    logic              res_rdy;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;

    modport slave (
        input  req, smp_data, smp_vld, dp_y, res_rdy,
        output gnt, smp_rdy, dp_clr, dp_en, dp_in, res_vld, res_data, res_id
    );

    modport master (
        output req, smp_data, smp_vld, dp_y, res_rdy,
        input  gnt, smp_rdy, dp_clr, dp_en, dp_in, res_vld, res_data, res_id
    );
endinterface

// File: rtl/acc_job_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/acc_job_sched.sv
// Shares one shift-accumulate datapath among NREQ requesters, one ITER-sample job at a time.
module acc_job_sched
    import acc_job_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int ITER = 100
) (
    input logic           clk,
    input logic           rst_n,
    acc_job_sched_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [IDW-1:0]  sel, ptr, arb_idx;
    logic [NREQ-1:0] arb_gnt, gnt_q;
    logic            arb_any;
    logic [CW-1:0]   cnt;
    logic            res_vld_q;
    logic [W-1:0]    res_data_q;
    logic [IDW-1:0]  res_id_q;
    logic            smp_ok, last_smp, res_acc;
    logic [7:0]      smp_sel;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign smp_sel  = bus.smp_data[8*int'(sel) +: 8];
    assign smp_ok   = (state == RUN) && bus.smp_vld[sel];
    assign last_smp = smp_ok && (cnt == CW'(ITER - 1));
    assign res_acc  = res_vld_q && bus.res_rdy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any)  state_nxt = CLEAR;
            CLEAR:                 state_nxt = RUN;
            RUN:     if (last_smp) state_nxt = RESULT;
            RESULT:  if (res_acc)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // gnt_q is onehot(sel) during a job, so it doubles as the sample-ready mask.
    assign bus.gnt      = gnt_q;
    assign bus.smp_rdy  = (state == RUN) ? gnt_q : '0;
    assign bus.dp_clr   = (state == CLEAR);
    assign bus.dp_en    = smp_ok;
    assign bus.dp_in    = (state == RUN) ? smp_sel : 8'h00;
    assign bus.res_vld  = res_vld_q;
    assign bus.res_data = res_data_q;
    assign bus.res_id   = res_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            ptr        <= '0;
            gnt_q      <= '0;
            cnt        <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        sel   <= arb_idx;
                        gnt_q <= arb_gnt;
                        ptr   <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    end
                end
                CLEAR: cnt <= '0;
                RUN:   if (smp_ok) cnt <= cnt + 1'b1;
                RESULT: begin
                    // First RESULT cycle: the last sample has now landed in dp_y.
                    if (!res_vld_q) begin
                        res_vld_q  <= 1'b1;
                        res_data_q <= bus.dp_y;
                        res_id_q   <= sel;
                    end else if (bus.res_rdy) begin
                        res_vld_q <= 1'b0;
                        gnt_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/acc_job_sched.md
Name: acc_job_sched

Overview:
- Scheduler that shares one shift-accumulate datapath among NREQ requesters. The datapath computes y <= 2*y + sign_ext(in), registered, signed, W bits.
- Arbitrates round-robin and gives the winner exclusive use of the datapath for one job of ITER samples.
- Sequences datapath clear/enable, counts accepted samples, and returns the W-bit result tagged with the requester id over a valid/ready handshake.
- Sits between client blocks and the single accumulator instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, datapath/result width.
- ITER, 100, samples per job (2..127).
- IDW and CW are localparams, not overridable: IDW = clog2(NREQ); CW = 7 (iteration counter width).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester job request, level.
- gnt  out  NREQ  one-hot grant; held from job start until result accepted.
- smp_data  in  NREQ*8  per-requester signed sample; slice i is [8i+7:8i].
- smp_vld  in  NREQ  per-requester sample valid.
- smp_rdy  out  NREQ  per-requester sample ready.
- dp_clr  out  1  synchronous clear of datapath register.
- dp_en  out  1  datapath update enable.
- dp_in  out  8  sample to datapath.
- dp_y  in  W  datapath register output.
- res_vld  out  1  result valid.
- res_rdy  in  1  result ready.
- res_data  out  W  job result.
- res_id  out  IDW  index of requester that owned the job.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; gnt=0, smp_rdy=0, dp_clr=0, dp_en=0, dp_in=0, res_vld=0, res_data=0, res_id=0; counter=0; rr pointer=0.
- The FSM has four states: IDLE, CLEAR, RUN, RESULT.
- IDLE:
  - If req != 0, select the first set bit searching from rr pointer upward with wrap.
  - Latch its index into sel; gnt <= onehot(sel); go to CLEAR.
  - Update rr pointer <= sel+1 mod NREQ.
- CLEAR: dp_clr=1 for exactly one cycle; counter <= 0; go to RUN.
- RUN:
  - smp_rdy[sel]=1; all other smp_rdy bits are 0.
  - dp_in = smp_data slice sel (combinational mux); dp_en = smp_vld[sel].
  - Each cycle with smp_vld[sel]=1 counts one sample; counter increments.
  - Gaps (smp_vld=0) stall the job, with no datapath update.
  - On the accepted sample where counter==ITER-1, go to RESULT.
- RESULT:
  - Entry is one cycle after the last dp_en, so dp_y already holds the final value.
  - On entry, latch res_data <= dp_y and res_id <= sel; assert res_vld.
  - Hold res_data, res_id and gnt stable until res_vld && res_rdy.
  - On that cycle: drop res_vld and gnt; go to IDLE.
- Latency: minimum one cycle from req to gnt, and (ITER+2) cycles from gnt to res_vld with back-to-back samples.
- A new grant cannot be issued in the same cycle the result is accepted, so one IDLE cycle always separates jobs.
- req deassertion mid-job is ignored; the job completes.
- The requester must not use smp_rdy outside its grant; samples on non-granted ports are never consumed.
- Arithmetic: two's-complement, wraps modulo 2^W; there is no saturation or overflow flag.
- gnt is always one-hot or zero; dp_en is never 1 outside RUN; dp_clr and dp_en are never both 1.
- Reset mid-job aborts immediately; the partial result is discarded. After reset the datapath is cleared by the next CLEAR state.

Decomposition:
- Shared package: state encoding enum (IDLE/CLEAR/RUN/RESULT) and the CW constant.
- One natural sub-module: rr_arbiter (NREQ, req, pointer -> one-hot grant + index), combinational, reusable.
- The FSM, counter, sample mux and result register stay in the top.

Test Plan:
- NREQ=4, ITER=4, requester 0 sends 1,2,3,4 back-to-back -> res_vld after 6 cycles from gnt; res_data=26, res_id=0.
- ITER=4, requester 2 sends -1 x4 -> res_data=0xFFFFFFF1 (-15), res_id=2; sign extension verified.
- ITER=100, all samples +1 -> res_data=0xFFFFFFFF (wrap of 2^100-1); all samples 0 -> 0.
- All four req held high -> jobs served in order 0,1,2,3,0.
  - gnt is one-hot at all times.
  - At least one IDLE cycle between jobs.
- Random smp_vld gaps and res_rdy held low 10 cycles -> result unchanged by gaps; res_data/res_id/gnt stable while stalled; single transfer on res_rdy.
- rst_n pulsed low mid-RUN (after 2 of 4 samples) -> all outputs zero immediately. The next job returns a correct result, unaffected by the aborted partial sum.
